// File: rtl/noc_pkg.sv
// Shared types and constants for the tree-NoC PE interfaces.
// Packet layout, most significant first: source, destination, payload.
package noc_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 8;
    localparam int PKT_W  = 14;

    typedef struct packed {
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] payload;
    } packet_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_ACK_HI = 2'd1,
        WAIT_ACK_LO = 2'd2
    } tx_state_t;

    function automatic packet_t make_packet(input logic [ADDR_W-1:0] src,
                                            input logic [ADDR_W-1:0] dst,
                                            input logic [DATA_W-1:0] payload);
        packet_t p;
        p.src     = src;
        p.dst     = dst;
        p.payload = payload;
        return p;
    endfunction

endpackage

// File: rtl/noc_tx_fifo.sv
// Synchronous packet FIFO; occupancy is tracked by an explicit count so that
// full/empty never depend on pointer comparison.
module noc_tx_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  packet_t                wdata,
    output packet_t                rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    packet_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_s;
    logic             pop_s;

    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign full   = (count_q == DEPTH_C);
    assign empty  = (count_q == '0);
    assign count  = count_q;
    assign rdata  = mem_q[rd_ptr_q];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/noc_tx_interface.sv
// PE-to-router transmit interface: buffers PE requests and launches each
// packet as a 4-phase bundled-data transfer with data held until ack falls.
module noc_tx_interface
    import noc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] NODE_ADDR    = 3'b000,
    parameter int                DEPTH        = 4,
    parameter int                WIDTH_packet = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pe_valid,
    output logic                    pe_ready,
    input  logic [ADDR_W-1:0]       pe_dest,
    input  logic [DATA_W-1:0]       pe_data,
    output logic                    out_req,
    output logic [WIDTH_packet-1:0] out_data,
    input  logic                    out_ack,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [7:0]              drop_cnt
);

    logic                    accept_s;
    logic                    self_addr_s;
    logic                    fifo_push_s;
    logic                    fifo_pop_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    packet_t                 fifo_wdata_s;
    packet_t                 fifo_rdata_s;
    logic                    ack_meta_q;
    logic                    ack_sync_q;
    tx_state_t               state_q;
    tx_state_t               state_d;
    logic                    out_req_q;
    logic                    out_req_d;
    logic [WIDTH_packet-1:0] out_data_q;
    logic [WIDTH_packet-1:0] out_data_d;
    logic [7:0]              drop_cnt_q;

    assign pe_ready     = !fifo_full_s;
    assign accept_s     = pe_valid && pe_ready;
    assign self_addr_s  = (pe_dest == NODE_ADDR);
    assign fifo_push_s  = accept_s && !self_addr_s;
    assign fifo_wdata_s = make_packet(NODE_ADDR, pe_dest, pe_data);
    assign out_req      = out_req_q;
    assign out_data     = out_data_q;
    assign drop_cnt     = drop_cnt_q;

    noc_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .wdata (fifo_wdata_s),
        .rdata (fifo_rdata_s),
        .count (fifo_count),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Two-flop synchronizer for the router's asynchronous acknowledge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_meta_q <= 1'b0;
            ack_sync_q <= 1'b0;
        end else begin
            ack_meta_q <= out_ack;
            ack_sync_q <= ack_meta_q;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            out_req_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            out_req_q  <= out_req_d;
            out_data_q <= out_data_d;
        end
    end

    // Next-state logic; IDLE also waits for ack low so a reset mid-handshake is safe
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s && !ack_sync_q) state_d = WAIT_ACK_HI;
                else                              state_d = IDLE;
            end
            WAIT_ACK_HI: begin
                if (ack_sync_q) state_d = WAIT_ACK_LO;
                else            state_d = WAIT_ACK_HI;
            end
            WAIT_ACK_LO: begin
                if (!ack_sync_q) state_d = IDLE;
                else             state_d = WAIT_ACK_LO;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: out_data is loaded only at launch so it stays stable all handshake
    always_comb begin
        fifo_pop_s = 1'b0;
        out_req_d  = out_req_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty_s && !ack_sync_q) begin
                    fifo_pop_s = 1'b1;
                    out_req_d  = 1'b1;
                    out_data_d = fifo_rdata_s;
                end else begin
                    out_req_d  = 1'b0;
                end
            end
            WAIT_ACK_HI: begin
                if (ack_sync_q) out_req_d = 1'b0;
                else            out_req_d = 1'b1;
            end
            WAIT_ACK_LO: begin
                out_req_d = 1'b0;
            end
            default: begin
                out_req_d = 1'b0;
            end
        endcase
    end

    // Saturating count of self-addressed requests that were consumed and discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 8'd0;
        end else if (accept_s && self_addr_s && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_noc_tx_interface.sv
// Directed and randomized bench for noc_tx_interface; a queue of accepted
// packets and a saturating drop counter serve as the reference model.
module tb_noc_tx_interface;

    localparam logic [2:0] NODE  = 3'b010;
    localparam int         DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pe_valid;
    logic        pe_ready;
    logic [2:0]  pe_dest;
    logic [7:0]  pe_data;
    logic        out_req;
    logic [13:0] out_data;
    logic        out_ack;
    logic [2:0]  fifo_count;
    logic [7:0]  drop_cnt;

    int          tests = 0;
    int          fails = 0;
    logic [13:0] pend_q[$];
    int          drop_m = 0;
    int          acks_done = 0;
    bit          push_done = 1'b1;
    bit          stress_end = 1'b0;

    noc_tx_interface #(.NODE_ADDR(NODE), .DEPTH(DEPTH), .WIDTH_packet(14)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pe_valid   (pe_valid),
        .pe_ready   (pe_ready),
        .pe_dest    (pe_dest),
        .pe_data    (pe_data),
        .out_req    (out_req),
        .out_data   (out_data),
        .out_ack    (out_ack),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request from the PE; the model records it only if pe_ready was high
    task automatic push(input logic [2:0] d, input logic [7:0] v);
        logic rdy;
        @(negedge clk);
        rdy      = pe_ready;
        pe_valid = 1'b1;
        pe_dest  = d;
        pe_data  = v;
        @(negedge clk);
        pe_valid = 1'b0;
        if (rdy) begin
            if (d == NODE) drop_m = (drop_m < 255) ? drop_m + 1 : 255;
            else           pend_q.push_back({NODE, d, v});
        end
    endtask

    task automatic wait_req(input logic lvl, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (out_req === lvl) begin
                ok = 1'b1;
                break;
            end
            #1;
        end
    endtask

    // Router side of one 4-phase handshake with random asynchronous delays
    task automatic serve_one(input int maxd);
        bit          ok;
        logic [13:0] got;
        logic [13:0] exp;
        for (int i = 0; i < 3000; i++) begin
            if (out_req === 1'b1 || (push_done && pend_q.size() == 0)) break;
            #1;
        end
        if (out_req !== 1'b1) begin
            if (pend_q.size() != 0) begin
                chk("req_timeout", out_req, 1);
                pend_q.delete();
            end
            return;
        end
        got = out_data;
        chk("launch_has_model_entry", 32'(pend_q.size() > 0), 1);
        if (pend_q.size() > 0) begin
            exp = pend_q.pop_front();
            chk("packet_order", got, exp);
        end
        #($urandom_range(1, maxd));
        chk("req_held_until_ack", out_req, 1);
        out_ack = 1'b1;
        wait_req(1'b0, ok);
        chk("req_fall", ok, 1);
        chk("data_stable_ack_hi", out_data, got);
        #($urandom_range(1, maxd));
        out_ack = 1'b0;
        acks_done++;
    endtask

    initial begin
        bit ok;
        rst_n    = 1'b0;
        out_ack  = 1'b0;
        pe_valid = 1'b0;
        pe_dest  = 3'd0;
        pe_data  = 8'd0;
        repeat (2) @(negedge clk);
        chk("rst_out_req", out_req, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_pe_ready", pe_ready, 1);
        rst_n = 1'b1;

        // Single packet: format, launch latency, ack-to-req-low latency
        push(3'b000, 8'hA3);
        chk("req_not_early", out_req, 0);
        chk("count_after_push", fifo_count, 1);
        @(negedge clk);
        chk("req_one_edge_after", out_req, 1);
        chk("pkt_format", out_data, 14'b010_000_10100011);
        chk("count_after_launch", fifo_count, 0);
        void'(pend_q.pop_front());
        out_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (out_req === 1'b0) break;
        end
        chk("req_fall_within_3", out_req, 0);
        out_ack = 1'b0;
        acks_done++;
        repeat (4) @(negedge clk);
        chk("idle_req_low", out_req, 0);
        chk("data_retained", out_data, 14'b010_000_10100011);

        // Fill the FIFO behind a packet stalled waiting for ack
        push(3'd0, 8'($urandom));
        push(3'd1, 8'($urandom));
        push(3'd3, 8'($urandom));
        push(3'd4, 8'($urandom));
        push(3'd5, 8'($urandom));
        chk("full_count", fifo_count, 4);
        chk("full_not_ready", pe_ready, 0);
        push(3'd6, 8'hEE);
        chk("full_reject_count", fifo_count, 4);
        chk("model_size_full", pend_q.size(), 5);
        repeat (5) serve_one(7);
        repeat (4) @(negedge clk);
        chk("drained_count", fifo_count, 0);
        chk("drained_ready", pe_ready, 1);

        // Self-addressed requests are dropped and counted with saturation
        push(NODE, 8'h55);
        chk("drop_one", drop_cnt, drop_m);
        chk("drop_no_store", fifo_count, 0);
        chk("drop_no_req", out_req, 0);
        @(negedge clk);
        pe_valid = 1'b1;
        pe_dest  = NODE;
        repeat (299) @(negedge clk);
        pe_valid = 1'b0;
        drop_m   = (drop_m + 299 > 255) ? 255 : drop_m + 299;
        chk("drop_saturate", drop_cnt, drop_m);
        chk("drop_sat_count", fifo_count, 0);

        // Ack already high: launch must wait for ack to fall
        out_ack = 1'b1;
        repeat (3) @(negedge clk);
        push(3'd6, 8'h5A);
        repeat (5) @(negedge clk);
        chk("ack_hi_no_req", out_req, 0);
        chk("ack_hi_count", fifo_count, 1);
        out_ack = 1'b0;
        serve_one(7);

        // Reset in WAIT_ACK_HI with ack high
        push(3'd7, 8'h11);
        push(3'd1, 8'h22);
        wait_req(1'b1, ok);
        chk("pre_reset_req", ok, 1);
        @(negedge clk);
        out_ack = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_req_drop", out_req, 0);
        chk("reset_count", fifo_count, 0);
        chk("reset_drop_cnt", drop_cnt, 0);
        pend_q.delete();
        drop_m = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(3'd3, 8'h33);
        repeat (6) @(negedge clk);
        chk("post_reset_no_req", out_req, 0);
        chk("post_reset_count", fifo_count, 1);
        out_ack = 1'b0;
        serve_one(7);
        repeat (3) @(negedge clk);
        chk("post_reset_drained", fifo_count, 0);

        // Random traffic against an asynchronous responder
        push_done = 1'b0;
        fork
            begin
                logic [2:0] d;
                for (int k = 0; k < 60; k++) begin
                    d = 3'($urandom_range(0, 7));
                    push(d, 8'($urandom));
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                end
                push_done = 1'b1;
            end
            begin
                for (int n = 0; n < 1000; n++) begin
                    if (push_done && pend_q.size() == 0) break;
                    serve_one(7);
                end
                stress_end = 1'b1;
            end
            begin
                logic        pr;
                logic [13:0] pd;
                int          launches;
                pr       = out_req;
                pd       = out_data;
                launches = acks_done;
                while (!stress_end) begin
                    @(negedge clk);
                    if (out_data !== pd) chk("data_change_only_at_launch", {pr, out_req}, 2'b01);
                    if (!pr && out_req) begin
                        chk("launch_after_handshake", launches, acks_done);
                        launches++;
                    end
                    pr = out_req;
                    pd = out_data;
                end
            end
        join
        repeat (4) @(negedge clk);
        chk("stress_count", fifo_count, 0);
        chk("stress_drop", drop_cnt, drop_m);
        chk("stress_req", out_req, 0);
        chk("stress_ready", pe_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
